// File: rtl/rocc_cmd_queue.sv
// Decoupling stage between the core RoCC port and an accelerator: DEPTH-entry
// command FIFO, one-entry response register, and an outstanding-response limiter.
module rocc_cmd_queue #(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            core_cmd_valid,
    output logic            core_cmd_ready,
    input  logic [6:0]      core_cmd_funct,
    input  logic [4:0]      core_cmd_rd,
    input  logic            core_cmd_xd,
    input  logic [XLEN-1:0] core_cmd_rs1,
    input  logic [XLEN-1:0] core_cmd_rs2,
    output logic            acc_cmd_valid,
    input  logic            acc_cmd_ready,
    output logic [6:0]      acc_cmd_funct,
    output logic [4:0]      acc_cmd_rd,
    output logic            acc_cmd_xd,
    output logic [XLEN-1:0] acc_cmd_rs1,
    output logic [XLEN-1:0] acc_cmd_rs2,
    input  logic            acc_resp_valid,
    output logic            acc_resp_ready,
    input  logic [4:0]      acc_resp_rd,
    input  logic [XLEN-1:0] acc_resp_data,
    output logic            core_resp_valid,
    input  logic            core_resp_ready,
    output logic [4:0]      core_resp_rd,
    output logic [XLEN-1:0] core_resp_data,
    input  logic            acc_busy,
    output logic            core_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int CMD_W = 13 + 2 * XLEN;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] out_cnt;

    logic             resp_vld_p1;
    logic [4:0]       resp_rd_p1;
    logic [XLEN-1:0]  resp_data_p1;

    logic enq, deq, resp_load, resp_take, out_inc;

    // A stray response with nothing outstanding must not wrap the counter.
    function automatic logic [OUT_W-1:0] sat_dec(input logic [OUT_W-1:0] x);
        return (x == '0) ? '0 : x - 1'b1;
    endfunction

    assign core_cmd_ready = !reset && (count != DEPTH_C) &&
                            !(core_cmd_xd && (out_cnt == MAX_OUT_C));
    assign acc_cmd_valid  = (count != '0);
    assign enq            = core_cmd_valid && core_cmd_ready;
    assign deq            = acc_cmd_valid && acc_cmd_ready;
    assign out_inc        = enq && core_cmd_xd;

    assign acc_resp_ready  = !resp_vld_p1 || core_resp_ready;
    assign resp_load       = acc_resp_valid && acc_resp_ready;
    assign resp_take       = resp_vld_p1 && core_resp_ready;
    assign core_resp_valid = resp_vld_p1;
    assign core_resp_rd    = resp_rd_p1;
    assign core_resp_data  = resp_data_p1;

    assign {acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_rs1, acc_cmd_rs2} = mem[rd_ptr];

    assign core_busy = (count != '0) || resp_vld_p1 || (out_cnt != '0) || acc_busy;

    // Control state: FIFO bookkeeping, response valid, outstanding count
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_cnt     <= '0;
            resp_vld_p1 <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
            if (out_inc && !resp_take)      out_cnt <= out_cnt + 1'b1;
            else if (resp_take && !out_inc) out_cnt <= sat_dec(out_cnt);
            if (resp_load)      resp_vld_p1 <= 1'b1;
            else if (resp_take) resp_vld_p1 <= 1'b0;
        end
    end

    // Data path: FIFO storage and response payload are never reset
    always_ff @(posedge clock) begin
        if (enq) mem[wr_ptr] <= {core_cmd_funct, core_cmd_rd, core_cmd_xd, core_cmd_rs1, core_cmd_rs2};
        if (resp_load) begin
            resp_rd_p1   <= acc_resp_rd;
            resp_data_p1 <= acc_resp_data;
        end
    end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Directed bench for rocc_cmd_queue: reset, single command, full FIFO,
// outstanding limit, response backpressure, simultaneous events, mid-run reset.
module tb_rocc_cmd_queue;
    localparam int XLEN = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            core_cmd_valid, core_cmd_ready;
    logic [6:0]      core_cmd_funct;
    logic [4:0]      core_cmd_rd;
    logic            core_cmd_xd;
    logic [XLEN-1:0] core_cmd_rs1, core_cmd_rs2;
    logic            acc_cmd_valid, acc_cmd_ready;
    logic [6:0]      acc_cmd_funct;
    logic [4:0]      acc_cmd_rd;
    logic            acc_cmd_xd;
    logic [XLEN-1:0] acc_cmd_rs1, acc_cmd_rs2;
    logic            acc_resp_valid, acc_resp_ready;
    logic [4:0]      acc_resp_rd;
    logic [XLEN-1:0] acc_resp_data;
    logic            core_resp_valid, core_resp_ready;
    logic [4:0]      core_resp_rd;
    logic [XLEN-1:0] core_resp_data;
    logic            acc_busy, core_busy;

    int ncmp = 0;
    int nfail = 0;

    rocc_cmd_queue #(.XLEN(XLEN), .DEPTH(4), .MAX_OUT(8)) dut (
        .clock(clock), .reset(reset),
        .core_cmd_valid(core_cmd_valid), .core_cmd_ready(core_cmd_ready),
        .core_cmd_funct(core_cmd_funct), .core_cmd_rd(core_cmd_rd), .core_cmd_xd(core_cmd_xd),
        .core_cmd_rs1(core_cmd_rs1), .core_cmd_rs2(core_cmd_rs2),
        .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
        .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
        .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
        .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
        .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
        .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
        .core_resp_rd(core_resp_rd), .core_resp_data(core_resp_data),
        .acc_busy(acc_busy), .core_busy(core_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_idle;
        core_cmd_valid = 0; core_cmd_funct = 0; core_cmd_rd = 0; core_cmd_xd = 0;
        core_cmd_rs1 = 0; core_cmd_rs2 = 0; acc_cmd_ready = 0;
        acc_resp_valid = 0; acc_resp_rd = 0; acc_resp_data = 0;
        core_resp_ready = 0; acc_busy = 0;
    endtask

    task automatic do_reset;
        set_idle();
        reset = 1;
        tick();
        reset = 0;
        settle();
    endtask

    task automatic send_cmd(input logic [6:0] f, input logic xd, input logic [XLEN-1:0] r1);
        core_cmd_valid = 1; core_cmd_funct = f; core_cmd_rd = f[4:0]; core_cmd_xd = xd;
        core_cmd_rs1 = r1; core_cmd_rs2 = r1 + 1;
        settle();
    endtask

    task automatic test_reset;
        set_idle();
        reset = 1;
        tick(); tick();
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL rst_cmd_ready: got %0h want 0", core_cmd_ready); end
        ncmp++; if (acc_cmd_valid !== 1'b0) begin nfail++; $display("FAIL rst_acc_vld: got %0h want 0", acc_cmd_valid); end
        ncmp++; if (core_resp_valid !== 1'b0) begin nfail++; $display("FAIL rst_resp_vld: got %0h want 0", core_resp_valid); end
        ncmp++; if (acc_resp_ready !== 1'b1) begin nfail++; $display("FAIL rst_resp_rdy: got %0h want 1", acc_resp_ready); end
        ncmp++; if (core_busy !== 1'b0) begin nfail++; $display("FAIL rst_busy0: got %0h want 0", core_busy); end
        acc_busy = 1; settle();
        ncmp++; if (core_busy !== 1'b1) begin nfail++; $display("FAIL rst_busy1: got %0h want 1", core_busy); end
        acc_busy = 0;
        reset = 0; settle();
        ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %0h want 1", core_cmd_ready); end
    endtask

    task automatic test_single;
        do_reset();
        core_cmd_valid = 1; core_cmd_funct = 7'd3; core_cmd_rd = 5'd5; core_cmd_xd = 1;
        core_cmd_rs1 = 64'h10; core_cmd_rs2 = 64'h20; settle();
        ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL single_ready: got %0h want 1", core_cmd_ready); end
        ncmp++; if (acc_cmd_valid !== 1'b0) begin nfail++; $display("FAIL single_no_bypass: got %0h want 0", acc_cmd_valid); end
        tick();
        core_cmd_valid = 0; settle();
        ncmp++; if (acc_cmd_valid !== 1'b1) begin nfail++; $display("FAIL single_acc_vld: got %0h want 1", acc_cmd_valid); end
        ncmp++; if ({acc_cmd_funct, acc_cmd_rd, acc_cmd_xd} !== {7'd3, 5'd5, 1'b1}) begin nfail++; $display("FAIL single_fields: got %0h/%0h/%0h want 3/5/1", acc_cmd_funct, acc_cmd_rd, acc_cmd_xd); end
        ncmp++; if (acc_cmd_rs1 !== 64'h10 || acc_cmd_rs2 !== 64'h20) begin nfail++; $display("FAIL single_ops: got %0h/%0h want 10/20", acc_cmd_rs1, acc_cmd_rs2); end
        ncmp++; if (dut.out_cnt !== 4'd1) begin nfail++; $display("FAIL single_out1: got %0d want 1", dut.out_cnt); end
        ncmp++; if (core_busy !== 1'b1) begin nfail++; $display("FAIL single_busy1: got %0h want 1", core_busy); end
        acc_cmd_ready = 1; tick(); acc_cmd_ready = 0; settle();
        ncmp++; if (acc_cmd_valid !== 1'b0) begin nfail++; $display("FAIL single_deq: got %0h want 0", acc_cmd_valid); end
        acc_resp_valid = 1; acc_resp_rd = 5'd5; acc_resp_data = 64'h30; settle();
        ncmp++; if (acc_resp_ready !== 1'b1) begin nfail++; $display("FAIL single_resp_rdy: got %0h want 1", acc_resp_ready); end
        tick(); acc_resp_valid = 0; settle();
        ncmp++; if (core_resp_valid !== 1'b1 || core_resp_rd !== 5'd5 || core_resp_data !== 64'h30) begin nfail++; $display("FAIL single_resp: got v%0h rd%0h d%0h want v1 rd5 d30", core_resp_valid, core_resp_rd, core_resp_data); end
        core_resp_ready = 1; tick(); core_resp_ready = 0; settle();
        ncmp++; if (core_resp_valid !== 1'b0) begin nfail++; $display("FAIL single_resp_clr: got %0h want 0", core_resp_valid); end
        ncmp++; if (dut.out_cnt !== 4'd0) begin nfail++; $display("FAIL single_out0: got %0d want 0", dut.out_cnt); end
        ncmp++; if (core_busy !== 1'b0) begin nfail++; $display("FAIL single_busy0: got %0h want 0", core_busy); end
    endtask

    task automatic test_full_fifo;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_cmd(7'(i + 1), 1'b0, 64'(100 + i));
            ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL full_fill%0d: got %0h want 1", i, core_cmd_ready); end
            tick();
        end
        send_cmd(7'd5, 1'b0, 64'd104);
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL full_ready5: got %0h want 0", core_cmd_ready); end
        ncmp++; if (dut.count !== 3'd4) begin nfail++; $display("FAIL full_count: got %0d want 4", dut.count); end
        acc_cmd_ready = 1; settle();
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL full_no_deq_through: got %0h want 0", core_cmd_ready); end
        tick(); acc_cmd_ready = 0; settle();
        ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL full_ready_after_deq: got %0h want 1", core_cmd_ready); end
        tick(); core_cmd_valid = 0;
        acc_cmd_ready = 1; settle();
        for (int i = 1; i < 5; i++) begin
            ncmp++; if (acc_cmd_valid !== 1'b1 || acc_cmd_funct !== 7'(i + 1) || acc_cmd_rs1 !== 64'(100 + i)) begin nfail++; $display("FAIL full_drain%0d: got v%0h f%0d rs1 %0d want v1 f%0d rs1 %0d", i, acc_cmd_valid, acc_cmd_funct, acc_cmd_rs1, i + 1, 100 + i); end
            tick();
        end
        ncmp++; if (acc_cmd_valid !== 1'b0) begin nfail++; $display("FAIL full_empty: got %0h want 0", acc_cmd_valid); end
        acc_cmd_ready = 0;
    endtask

    task automatic test_outstanding_limit;
        do_reset();
        acc_cmd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            send_cmd(7'(i), 1'b1, 64'(i));
            ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL lim_accept%0d: got %0h want 1", i, core_cmd_ready); end
            tick();
        end
        send_cmd(7'd9, 1'b1, 64'd9);
        ncmp++; if (dut.out_cnt !== 4'd8) begin nfail++; $display("FAIL lim_out8: got %0d want 8", dut.out_cnt); end
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL lim_stall_xd1: got %0h want 0", core_cmd_ready); end
        core_cmd_xd = 0; settle();
        ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL lim_xd0_ok: got %0h want 1", core_cmd_ready); end
        tick();
        core_cmd_xd = 1;
        acc_resp_valid = 1; acc_resp_rd = 5'd1; acc_resp_data = 64'h55; core_resp_ready = 1;
        settle();
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL lim_still_stalled: got %0h want 0", core_cmd_ready); end
        tick(); acc_resp_valid = 0; settle();
        ncmp++; if (core_resp_valid !== 1'b1 || core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL lim_resp_pending: got v%0h rdy%0h want v1 rdy0", core_resp_valid, core_cmd_ready); end
        tick(); core_resp_ready = 0; settle();
        ncmp++; if (dut.out_cnt !== 4'd7 || core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL lim_release: got out%0d rdy%0h want out7 rdy1", dut.out_cnt, core_cmd_ready); end
        tick(); core_cmd_valid = 0; settle();
        ncmp++; if (dut.out_cnt !== 4'd8) begin nfail++; $display("FAIL lim_ninth_in: got %0d want 8", dut.out_cnt); end
        acc_cmd_ready = 0;
    endtask

    task automatic test_resp_backpressure;
        do_reset();
        acc_resp_valid = 1; acc_resp_rd = 5'd1; acc_resp_data = 64'hA; settle();
        ncmp++; if (acc_resp_ready !== 1'b1) begin nfail++; $display("FAIL bp_first_rdy: got %0h want 1", acc_resp_ready); end
        tick();
        acc_resp_rd = 5'd2; acc_resp_data = 64'hB; settle();
        ncmp++; if (acc_resp_ready !== 1'b0) begin nfail++; $display("FAIL bp_second_blocked: got %0h want 0", acc_resp_ready); end
        tick(); settle();
        ncmp++; if (core_resp_valid !== 1'b1 || core_resp_data !== 64'hA || core_resp_rd !== 5'd1) begin nfail++; $display("FAIL bp_hold_A: got v%0h d%0h rd%0h want v1 dA rd1", core_resp_valid, core_resp_data, core_resp_rd); end
        core_resp_ready = 1; settle();
        ncmp++; if (acc_resp_ready !== 1'b1) begin nfail++; $display("FAIL bp_comb_rdy: got %0h want 1", acc_resp_ready); end
        tick(); acc_resp_valid = 0; settle();
        ncmp++; if (core_resp_valid !== 1'b1 || core_resp_data !== 64'hB || core_resp_rd !== 5'd2) begin nfail++; $display("FAIL bp_B_next: got v%0h d%0h rd%0h want v1 dB rd2", core_resp_valid, core_resp_data, core_resp_rd); end
        tick(); core_resp_ready = 0; settle();
        ncmp++; if (core_resp_valid !== 1'b0) begin nfail++; $display("FAIL bp_drained: got %0h want 0", core_resp_valid); end
        ncmp++; if (dut.out_cnt !== 4'd0) begin nfail++; $display("FAIL bp_no_underflow: got %0d want 0", dut.out_cnt); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        send_cmd(7'd1, 1'b1, 64'd1); tick();
        core_cmd_valid = 0;
        acc_resp_valid = 1; acc_resp_rd = 5'd3; acc_resp_data = 64'h77; settle();
        tick(); acc_resp_valid = 0;
        send_cmd(7'd2, 1'b1, 64'd2);
        core_resp_ready = 1; settle();
        tick(); core_resp_ready = 0; settle();
        ncmp++; if (dut.out_cnt !== 4'd1) begin nfail++; $display("FAIL sim_out_same: got %0d want 1", dut.out_cnt); end
        ncmp++; if (dut.count !== 3'd2) begin nfail++; $display("FAIL sim_count2: got %0d want 2", dut.count); end
        send_cmd(7'd3, 1'b0, 64'd3);
        acc_cmd_ready = 1; settle();
        tick(); core_cmd_valid = 0; acc_cmd_ready = 0; settle();
        ncmp++; if (dut.count !== 3'd2) begin nfail++; $display("FAIL sim_count_hold: got %0d want 2", dut.count); end
        ncmp++; if (acc_cmd_funct !== 7'd2) begin nfail++; $display("FAIL sim_head: got %0d want 2", acc_cmd_funct); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_cmd(7'(i + 10), 1'b1, 64'(i)); tick();
        end
        core_cmd_valid = 0;
        acc_resp_valid = 1; acc_resp_data = 64'h99; settle();
        tick(); acc_resp_valid = 0;
        core_cmd_valid = 1; reset = 1; settle();
        ncmp++; if (core_cmd_ready !== 1'b0) begin nfail++; $display("FAIL mid_ready_in_rst: got %0h want 0", core_cmd_ready); end
        tick();
        core_cmd_valid = 0; reset = 0; settle();
        ncmp++; if (acc_cmd_valid !== 1'b0) begin nfail++; $display("FAIL mid_acc_vld: got %0h want 0", acc_cmd_valid); end
        ncmp++; if (core_resp_valid !== 1'b0) begin nfail++; $display("FAIL mid_resp_vld: got %0h want 0", core_resp_valid); end
        ncmp++; if (dut.out_cnt !== 4'd0) begin nfail++; $display("FAIL mid_out: got %0d want 0", dut.out_cnt); end
        ncmp++; if (core_busy !== 1'b0) begin nfail++; $display("FAIL mid_busy: got %0h want 0", core_busy); end
        core_cmd_xd = 1; settle();
        ncmp++; if (core_cmd_ready !== 1'b1) begin nfail++; $display("FAIL mid_ready_after: got %0h want 1", core_cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_fifo();
        test_outstanding_limit();
        test_resp_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/rocc_cmd_queue.md
# rocc_cmd_queue

Decoupling stage between the core's RoCC port and a RoCC accelerator. It buffers incoming commands in a DEPTH-entry FIFO. It registers accelerator responses in a one-entry pipeline register before returning them to the core. It tracks outstanding response-expecting commands, limits how many can be in flight, and drives a combined busy indication back to the core.

## Interface
Parameters:
- XLEN, 64, operand/result data width
- DEPTH, 4, command FIFO entries; power of two, ≥2
- MAX_OUT, 8, max outstanding xd=1 commands (enqueued, response not yet delivered to core); ≥1

Ports (command fields are packed as {funct[6:0], rd[4:0], xd, rs1[XLEN-1:0], rs2[XLEN-1:0]}):
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- core_cmd_valid  in  1  core command offered
- core_cmd_ready  out  1  stage accepts command
- core_cmd_funct  in  7  instruction funct
- core_cmd_rd  in  5  destination register
- core_cmd_xd  in  1  command expects a response
- core_cmd_rs1  in  XLEN  operand 1
- core_cmd_rs2  in  XLEN  operand 2
- acc_cmd_valid  out  1  FIFO head valid
- acc_cmd_ready  in  1  accelerator takes head
- acc_cmd_funct/rd/xd/rs1/rs2  out  7/5/1/XLEN/XLEN  FIFO head fields
- acc_resp_valid  in  1  accelerator response
- acc_resp_ready  out  1  response register can load
- acc_resp_rd  in  5  response destination
- acc_resp_data  in  XLEN  response data
- core_resp_valid  out  1  registered response valid
- core_resp_ready  in  1  core accepts response
- core_resp_rd  out  5  registered rd
- core_resp_data  out  XLEN  registered data
- acc_busy  in  1  accelerator internal busy
- core_busy  out  1  combined busy

## Operation
- Command enqueue fires on core_cmd_valid && core_cmd_ready. The full command is written at the write pointer.
- core_cmd_ready = !reset && count<DEPTH && !(core_cmd_xd && out_cnt==MAX_OUT).
  - There is no deq-through: when the FIFO is full, ready stays 0 even if acc_cmd_ready=1.
- Dequeue fires on acc_cmd_valid && acc_cmd_ready.
  - acc_cmd_valid = count>0.
  - acc_cmd_* fields present the head entry.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Response register:
  - acc_resp_ready = !core_resp_valid || core_resp_ready.
  - On acc_resp fire, rd and data load and core_resp_valid is set.
  - On core_resp fire without a new load, core_resp_valid clears.
  - Back-to-back responses sustain 1 per cycle.
- out_cnt is a $clog2(MAX_OUT+1)-bit counter.
  - It increments on an enqueue with xd=1.
  - It decrements on a core_resp fire.
  - Both in the same cycle: unchanged.
  - A decrement when out_cnt=0 is an accelerator protocol error. Hold the counter at 0 (no underflow).
- core_busy = count>0 || core_resp_valid || out_cnt>0 || acc_busy.
- Reset (synchronous): pointers, count, out_cnt, and core_resp_valid clear to 0. Reset mid-operation discards all queued commands and any held response.
  - Output values during and after reset: core_cmd_ready=0 while reset is high, then 1 on the first cycle after. acc_cmd_valid=0, core_resp_valid=0, acc_resp_ready=1, core_busy=acc_busy.
  - FIFO data storage is not reset. Head fields are don't-care while acc_cmd_valid=0. core_resp_rd/data are don't-care while core_resp_valid=0.

## Timing
- Command latency is 1 cycle: an enqueue at edge N makes acc_cmd_valid high after edge N (visible from cycle N+1). There is no combinational cmd bypass.
- Response latency is 1 cycle: acc_resp fire at edge N gives core_resp_valid from cycle N+1.
- core_cmd_ready depends combinationally on core_cmd_xd only via the out_cnt limit. All other outputs are register-derived, except acc_resp_ready (combinational on core_resp_ready) and core_busy (combinational on acc_busy).
- Full throughput is 1 command per cycle when the FIFO is neither full nor empty, or when the FIFO is empty and acc_cmd_ready is held high.

## Test plan
- **Single command:** after reset, enqueue funct=3, rd=5, xd=1, rs1=0x10, rs2=0x20.
  - Next cycle: acc_cmd_valid=1 with the same fields, out_cnt=1, core_busy=1.
  - After acc_cmd_ready, then acc_resp rd=5 data=0x30: core_resp_valid=1 (rd=5, data=0x30) one cycle later.
  - After the core accepts: out_cnt=0, core_busy=0.
- **Full FIFO:** acc_cmd_ready=0; enqueue 4 xd=0 commands → core_cmd_ready=0 on the 5th.
  - Assert acc_cmd_ready for 1 cycle → one head dequeued, core_cmd_ready=1 next cycle.
  - Drain order matches enqueue order.
- **Outstanding limit:** MAX_OUT=8, DEPTH=4, accelerator always ready and never responds. Enqueue 9 xd=1 commands.
  - The 9th is stalled: core_cmd_ready=0 with xd=1, but an xd=0 command is accepted.
  - One response delivered → the 9th is accepted.
- **Response backpressure:** two acc responses (data 0xA, 0xB) on consecutive cycles with core_resp_ready=0.
  - 0xA is held and acc_resp_ready=0 for the 2nd.
  - Release core_resp_ready → 0xA then 0xB delivered on consecutive cycles.
- **Simultaneous events:** enqueue xd=1 plus core_resp fire in the same cycle → out_cnt unchanged. Enqueue plus dequeue at count=2 → count stays 2.
- **Reset mid-operation:** 3 commands queued plus a response held, then assert reset for 1 cycle.
  - acc_cmd_valid=0, core_resp_valid=0, out_cnt=0.
  - core_cmd_ready=1 the cycle after reset deasserts.
